// File: rtl/reg_scoreboard_pkg.sv
// Shared configuration and types for the register write scoreboard.
package reg_scoreboard_pkg;

  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned REG_ZERO     = 0;
  localparam int unsigned TW           = 2;
  localparam int unsigned MAX_INFLIGHT = 3;
  localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned RA_W         = $clog2(NUM_REGS);

  typedef logic [RA_W-1:0]     reg_addr_t;
  typedef logic [TW-1:0]       tcyc_t;
  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback side bundle of the scoreboard: issue, source query, retire, status.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic      issue_valid;
  reg_addr_t issue_rd;
  tcyc_t     issue_tnew;
  reg_addr_t rs;
  tcyc_t     rs_tuse;
  reg_addr_t rt;
  tcyc_t     rt_tuse;
  logic      wb_en;
  reg_addr_t wb_rd;
  logic      stall;
  logic      issue_fire;
  reg_mask_t busy_mask;
  logic      ovf_err;
  logic      unf_err;

  // Pipeline control side: drives issue/query/retire, observes hazard status.
  modport master (
    output issue_valid, issue_rd, issue_tnew, rs, rs_tuse, rt, rt_tuse, wb_en, wb_rd,
    input  stall, issue_fire, busy_mask, ovf_err, unf_err
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, issue_rd, issue_tnew, rs, rs_tuse, rt, rt_tuse, wb_en, wb_rd,
    output stall, issue_fire, busy_mask, ovf_err, unf_err
  );

endinterface

// File: rtl/reg_scoreboard_sb_entry.sv
// One tracked register: outstanding-write count, readiness of the youngest write,
// and sticky overflow/underflow flags.
module reg_scoreboard_sb_entry
  import reg_scoreboard_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  issue_i,
  input  tcyc_t tnew_i,
  input  logic  retire_i,
  output logic  busy_o,
  output tcyc_t rdy_o,
  output logic  ovf_o,
  output logic  unf_o
);

  localparam cnt_t CntMax = cnt_t'(MAX_INFLIGHT);

  cnt_t  cnt_q, cnt_d;
  tcyc_t rdy_q, rdy_d;
  logic  ovf_q, ovf_d;
  logic  unf_q, unf_d;

  // Next-state: count follows issue/retire, readiness tracks the youngest issue.
  always_comb begin
    cnt_d = cnt_q;
    rdy_d = (rdy_q != '0) ? rdy_q - tcyc_t'(1) : '0;
    ovf_d = ovf_q;
    unf_d = unf_q;
    case ({issue_i, retire_i})
      2'b10: begin
        if (cnt_q == CntMax) ovf_d = 1'b1;
        else                 cnt_d = cnt_q + cnt_t'(1);
        rdy_d = tnew_i;
      end
      2'b01: begin
        if (cnt_q == '0) unf_d = 1'b1;
        else             cnt_d = cnt_q - cnt_t'(1);
      end
      2'b11: begin
        // Retire of an untracked write paired with a new issue: just the issue counts.
        if (cnt_q == '0) cnt_d = cnt_t'(1);
        rdy_d = tnew_i;
      end
      default: ;
    endcase
    // Nothing outstanding means nothing to wait for.
    if (cnt_d == '0) rdy_d = '0;
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      rdy_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign rdy_o  = rdy_q;
  assign ovf_o  = ovf_q;
  assign unf_o  = unf_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: tracks in-flight destination writes and stalls decode
// when a source operand cannot be read or forwarded in time.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input logic             clk,
  input logic             reset,
  reg_scoreboard_if.slave sb
);

  reg_mask_t busy_mask;
  reg_mask_t ovf_vec;
  reg_mask_t unf_vec;
  tcyc_t     rdy [NUM_REGS];
  logic      rs_haz, rt_haz;
  logic      stall;
  logic      issue_fire;

  // Register zero is hardwired: never busy, never ready-pending, never errors.
  assign busy_mask[REG_ZERO] = 1'b0;
  assign ovf_vec[REG_ZERO]   = 1'b0;
  assign unf_vec[REG_ZERO]   = 1'b0;
  assign rdy[REG_ZERO]       = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    logic issue_hit;
    logic retire_hit;

    assign issue_hit  = issue_fire && (sb.issue_rd == reg_addr_t'(i));
    assign retire_hit = sb.wb_en && (sb.wb_rd == reg_addr_t'(i));

    reg_scoreboard_sb_entry u_entry (
      .clk      (clk),
      .reset    (reset),
      .issue_i  (issue_hit),
      .tnew_i   (sb.issue_tnew),
      .retire_i (retire_hit),
      .busy_o   (busy_mask[i]),
      .rdy_o    (rdy[i]),
      .ovf_o    (ovf_vec[i]),
      .unf_o    (unf_vec[i])
    );
  end

  // Hazard check on registered state only; same-cycle issue/retire is not seen.
  always_comb begin
    rs_haz     = busy_mask[sb.rs] && (rdy[sb.rs] > sb.rs_tuse);
    rt_haz     = busy_mask[sb.rt] && (rdy[sb.rt] > sb.rt_tuse);
    stall      = rs_haz | rt_haz;
    issue_fire = sb.issue_valid & ~stall;
  end

  assign sb.stall      = stall;
  assign sb.issue_fire = issue_fire;
  assign sb.busy_mask  = busy_mask;
  assign sb.ovf_err    = |ovf_vec;
  assign sb.unf_err    = |unf_vec;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench: directed scenarios then random traffic against a count/readiness model.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  reg_scoreboard_if sb ();

  reg_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: outstanding writes and cycles-to-ready per register.
  int m_cnt [NUM_REGS];
  int m_rdy [NUM_REGS];
  bit m_ovf;
  bit m_unf;

  logic        o_stall;
  logic        o_fire;
  logic [31:0] o_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hazard(input int s, input int u);
    return (s != 0) && (m_cnt[s] != 0) && (m_rdy[s] > u);
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int i = 1; i < NUM_REGS; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_cnt[i] = 0;
      m_rdy[i] = 0;
    end
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic m_step(input bit fire, input int ird, input int itn, input bit we, input int wrd);
    for (int i = 1; i < NUM_REGS; i++) begin
      bit ii;
      bit ww;
      ii = fire && (ird == i);
      ww = we && (wrd == i);
      if (ii) begin
        if (ww) begin
          if (m_cnt[i] == 0) m_cnt[i] = 1;
        end else if (m_cnt[i] == MAX_INFLIGHT) begin
          m_ovf = 1'b1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
        m_rdy[i] = itn;
      end else begin
        if (ww) begin
          if (m_cnt[i] == 0) m_unf = 1'b1;
          else               m_cnt[i] = m_cnt[i] - 1;
        end
        if (m_rdy[i] > 0) m_rdy[i] = m_rdy[i] - 1;
      end
      if (m_cnt[i] == 0) m_rdy[i] = 0;
    end
  endtask

  task automatic drive(input bit iv, input int ird, input int itn, input int rs, input int rsu,
                       input int rt, input int rtu, input bit we, input int wrd);
    sb.issue_valid = iv;
    sb.issue_rd    = reg_addr_t'(ird);
    sb.issue_tnew  = tcyc_t'(itn);
    sb.rs          = reg_addr_t'(rs);
    sb.rs_tuse     = tcyc_t'(rsu);
    sb.rt          = reg_addr_t'(rt);
    sb.rt_tuse     = tcyc_t'(rtu);
    sb.wb_en       = we;
    sb.wb_rd       = reg_addr_t'(wrd);
  endtask

  // One clock: drive after negedge, check combinational outputs, advance model at posedge.
  task automatic cyc(input bit iv, input int ird, input int itn, input int rs, input int rsu,
                     input int rt, input int rtu, input bit we, input int wrd);
    bit exp_stall;
    bit exp_fire;
    @(negedge clk);
    drive(iv, ird, itn, rs, rsu, rt, rtu, we, wrd);
    #1;
    exp_stall = m_hazard(rs, rsu) || m_hazard(rt, rtu);
    exp_fire  = iv && !exp_stall;
    o_stall   = sb.stall;
    o_fire    = sb.issue_fire;
    o_busy    = sb.busy_mask;
    chk("stall", {31'b0, o_stall}, {31'b0, exp_stall});
    chk("issue_fire", {31'b0, o_fire}, {31'b0, exp_fire});
    chk("busy_mask", o_busy, m_busy());
    chk("ovf_err", {31'b0, sb.ovf_err}, {31'b0, m_ovf});
    chk("unf_err", {31'b0, sb.unf_err}, {31'b0, m_unf});
    @(posedge clk);
    m_step(exp_fire, ird, itn, we, wrd);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_busy", sb.busy_mask, 32'h0);
    chk("rst_stall", {31'b0, sb.stall}, 32'h0);
    chk("rst_ovf", {31'b0, sb.ovf_err}, 32'h0);
    chk("rst_unf", {31'b0, sb.unf_err}, 32'h0);
    m_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    m_clear();
    drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    do_reset();
    idle();

    // Load-use: tnew=2 result consumed immediately.
    cyc(1'b1, 8, 2, 0, 0, 0, 0, 1'b0, 0);
    cyc(1'b0, 0, 0, 8, 0, 0, 0, 1'b0, 0);
    chk("lu_stall_t1", {31'b0, o_stall}, 32'h1);
    cyc(1'b0, 0, 0, 8, 0, 0, 0, 1'b0, 0);
    chk("lu_stall_t2", {31'b0, o_stall}, 32'h1);
    cyc(1'b0, 0, 0, 8, 0, 0, 0, 1'b1, 8);
    chk("lu_stall_t3", {31'b0, o_stall}, 32'h0);
    chk("lu_busy_t3", {31'b0, o_busy[8]}, 32'h1);
    idle();
    chk("lu_busy_t4", {31'b0, o_busy[8]}, 32'h0);

    // Forwardable ALU result.
    cyc(1'b1, 5, 0, 0, 0, 0, 0, 1'b0, 0);
    cyc(1'b0, 0, 0, 0, 0, 5, 0, 1'b0, 0);
    chk("alu_stall", {31'b0, o_stall}, 32'h0);
    chk("alu_busy5", {31'b0, o_busy[5]}, 32'h1);

    // Same register in flight, overflow, drain, issue+retire.
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1'b1, 3, 1, 0, 0, 0, 0, 1'b0, 0);
    cyc(1'b1, 3, 1, 0, 0, 0, 0, 1'b0, 0);
    idle();
    chk("inf_ovf", {31'b0, sb.ovf_err}, 32'h1);
    chk("inf_busy3", {31'b0, o_busy[3]}, 32'h1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 3);
    idle();
    chk("inf_drained", {31'b0, o_busy[3]}, 32'h0);
    cyc(1'b1, 3, 1, 0, 0, 0, 0, 1'b0, 0);
    cyc(1'b1, 3, 1, 0, 0, 0, 0, 1'b1, 3);
    idle();
    chk("inf_iw_keep", {31'b0, o_busy[3]}, 32'h1);
    cyc(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 3);
    idle();
    chk("inf_iw_done", {31'b0, o_busy[3]}, 32'h0);
    chk("inf_no_unf", {31'b0, sb.unf_err}, 32'h0);

    // Register zero and underflow.
    do_reset();
    cyc(1'b1, 0, 3, 0, 0, 0, 0, 1'b0, 0);
    cyc(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 0);
    chk("r0_busy", o_busy, 32'h0);
    chk("r0_stall", {31'b0, o_stall}, 32'h0);
    cyc(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 9);
    idle();
    chk("unf_set", {31'b0, sb.unf_err}, 32'h1);
    for (int k = 0; k < 3; k++) idle();
    chk("unf_sticky", {31'b0, sb.unf_err}, 32'h1);
    do_reset();

    // Stalled issue is suppressed.
    cyc(1'b1, 8, 3, 0, 0, 0, 0, 1'b0, 0);
    cyc(1'b1, 12, 1, 8, 0, 0, 0, 1'b0, 0);
    chk("sup_stall", {31'b0, o_stall}, 32'h1);
    chk("sup_fire", {31'b0, o_fire}, 32'h0);
    idle();
    chk("sup_busy12", {31'b0, o_busy[12]}, 32'h0);

    // Random traffic over a small register window to provoke hazards.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ((n % 150) == 149) do_reset();
      cyc(($urandom_range(1) == 1), int'($urandom_range(7)), int'($urandom_range(3)),
          int'($urandom_range(7)), int'($urandom_range(3)),
          int'($urandom_range(7)), int'($urandom_range(3)),
          ($urandom_range(2) == 0), int'($urandom_range(7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
